// File: rtl/face_scan_sequencer.sv
// Multi-scale sliding-window scan sequencer for one 3U x 3U face-detection tile.
// Walks six filter stages, emitting one window descriptor per accepted handshake.
module face_scan_sequencer #(
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [DW-1:0] unit_size_i,
    output logic          win_valid_o,
    input  logic          win_ready_i,
    output logic [DW-1:0] win_x_o,
    output logic [DW-1:0] win_y_o,
    output logic [AW-1:0] win_addr_o,
    output logic [DW-1:0] filt_w_o,
    output logic [DW-1:0] filt_h_o,
    output logic [DW-1:0] eye_w_o,
    output logic [2:0]    stage_o,
    input  logic          hit_i,
    output logic [CW-1:0] det_count_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    state_o
);
    // Internal arithmetic is wide enough for 15U without wrap.
    localparam int EW = DW + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Handshake: a descriptor transfers on a rising edge with win_valid_o && win_ready_i;
    // once valid is raised, valid and every descriptor field hold until that transfer.

    state_e        state_q, state_d;
    logic [DW-1:0] u_q, u_d;
    logic [EW-1:0] x_q, x_d, y_q, y_d;
    logic [AW-1:0] addr_q, addr_d, row_q, row_d;
    logic [2:0]    stg_q, stg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [EW-1:0] tu;
    logic [EW-1:0] w1, w2, w3, w4, w5, raw6;
    logic [EW-1:0] cw_w  [1:6];
    logic [EW-1:0] cw_h  [1:6];
    logic [EW-1:0] cw_e  [1:6];
    logic [EW-1:0] cw_xm [1:6];
    logic [EW-1:0] cw_ym [1:6];
    logic [6:1]    cw_ok;

    logic [DW-1:0] tw_q  [1:6];
    logic [DW-1:0] th_q  [1:6];
    logic [DW-1:0] te_q  [1:6];
    logic [EW-1:0] txm_q [1:6];
    logic [EW-1:0] tym_q [1:6];
    logic [6:1]    tok_q;

    logic          busy, accept, at_row_end, at_last_row, last_win;
    logic [2:0]    first_stg, next_stg;
    logic [EW-1:0] xm_cur, ym_cur;

    // Lowest valid stage strictly above cur, or 0 when none remains.
    function automatic logic [2:0] next_stage(input logic [6:1] ok, input logic [2:0] cur);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 6; i >= 1; i--) begin
            if (ok[i] && (3'(i) > cur)) r = 3'(i);
        end
        return r;
    endfunction

    // Stage geometry from the latched unit size, captured into the table during CALC.
    always_comb begin
        tu   = EW'(u_q) * EW'(3);
        w1   = (EW'(u_q) * EW'(2)) / EW'(3);
        w2   = (w1 * EW'(3)) / EW'(2);
        w3   = (w2 * EW'(3)) / EW'(2);
        w4   = (w3 * EW'(4)) / EW'(3);
        w5   = (w4 * EW'(5)) / EW'(4);
        raw6 = (w5 * EW'(6)) / EW'(5);
        cw_w[1] = w1;
        cw_w[2] = w2;
        cw_w[3] = w3;
        cw_w[4] = w4;
        cw_w[5] = w5;
        cw_w[6] = (raw6 == '0) ? '0 : raw6 - EW'(1);
        for (int i = 1; i <= 6; i++) begin
            cw_h[i]  = cw_w[i] / EW'(6);
            cw_e[i]  = cw_w[i] / EW'(5);
            cw_ok[i] = (cw_h[i] != '0) && (cw_e[i] != '0) &&
                       (tu > cw_w[i]) && (tu > (cw_h[i] << 2));
            cw_xm[i] = tu - cw_w[i] - EW'(1);
            cw_ym[i] = tu - (cw_h[i] << 2) - EW'(1);
        end
    end

    always_comb begin
        busy        = (state_q == S_CALC) || (state_q == S_SCAN);
        accept      = (state_q == S_SCAN) && win_ready_i;
        xm_cur      = txm_q[stg_q];
        ym_cur      = tym_q[stg_q];
        at_row_end  = (x_q >= xm_cur);
        at_last_row = (y_q >= ym_cur);
        first_stg   = next_stage(cw_ok, 3'd0);
        next_stg    = next_stage(tok_q, stg_q);
        last_win    = at_row_end && at_last_row && (next_stg == 3'd0);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CALC;
            end
            S_CALC: begin
                if (abort_i)                state_d = S_IDLE;
                else if (first_stg == 3'd0) state_d = S_DONE;
                else                        state_d = S_SCAN;
            end
            S_SCAN: begin
                if (abort_i)                 state_d = S_IDLE;
                else if (accept && last_win) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Window walk: row_q tracks y*3U incrementally so no multiplier is needed.
    always_comb begin
        u_d    = u_q;
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        row_d  = row_q;
        stg_d  = stg_q;
        cnt_d  = cnt_q;
        if ((state_q == S_IDLE) && start_i) begin
            u_d   = unit_size_i;
            cnt_d = '0;
        end else if (busy && hit_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (state_q == S_CALC) begin
            stg_d  = first_stg;
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            row_d  = '0;
        end else if (accept && !abort_i) begin
            if (!at_row_end) begin
                x_d    = x_q + EW'(1);
                addr_d = addr_q + AW'(1);
            end else if (!at_last_row) begin
                x_d    = '0;
                y_d    = y_q + EW'(1);
                row_d  = row_q + AW'(tu);
                addr_d = row_q + AW'(tu);
            end else begin
                stg_d  = next_stg;
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
                row_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            u_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            row_q  <= '0;
            stg_q  <= '0;
            cnt_q  <= '0;
        end else begin
            u_q    <= u_d;
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
            row_q  <= row_d;
            stg_q  <= stg_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tok_q <= '0;
            for (int i = 1; i <= 6; i++) begin
                tw_q[i]  <= '0;
                th_q[i]  <= '0;
                te_q[i]  <= '0;
                txm_q[i] <= '0;
                tym_q[i] <= '0;
            end
        end else if (state_q == S_CALC) begin
            tok_q <= cw_ok;
            for (int i = 1; i <= 6; i++) begin
                tw_q[i]  <= cw_w[i][DW-1:0];
                th_q[i]  <= cw_h[i][DW-1:0];
                te_q[i]  <= cw_e[i][DW-1:0];
                txm_q[i] <= cw_xm[i];
                tym_q[i] <= cw_ym[i];
            end
        end
    end

    always_comb begin
        win_valid_o = 1'b0;
        win_x_o     = '0;
        win_y_o     = '0;
        win_addr_o  = '0;
        filt_w_o    = '0;
        filt_h_o    = '0;
        eye_w_o     = '0;
        stage_o     = 3'd0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_CALC: busy_o = 1'b1;
            S_SCAN: begin
                busy_o      = 1'b1;
                win_valid_o = 1'b1;
                win_x_o     = x_q[DW-1:0];
                win_y_o     = y_q[DW-1:0];
                win_addr_o  = addr_q;
                filt_w_o    = tw_q[stg_q];
                filt_h_o    = th_q[stg_q];
                eye_w_o     = te_q[stg_q];
                stage_o     = stg_q;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
        det_count_o = cnt_q;
        state_o     = state_q;
    end

endmodule

// File: tb/tb_face_scan_sequencer.sv
// Bench for face_scan_sequencer: table-driven scans, randomized backpressure and
// hits checked against a window-list model, plus abort/reset/restart/saturation cases.
module tb_face_scan_sequencer;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [2:0]    stage;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [AW-1:0] addr;
        logic [DW-1:0] w;
        logic [DW-1:0] h;
        logic [DW-1:0] e;
    } desc_t;
    localparam int DESC_W = $bits(desc_t);

    typedef struct {
        int u;
        int rdy;
        int windows;
        int first_stage;
        int first_w;
        int last_addr;
        int det;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          win_ready = 1'b0;
    logic          hit = 1'b0;
    logic [DW-1:0] unit_size = '0;

    logic          win_valid, busy, done;
    logic [DW-1:0] win_x, win_y, filt_w, filt_h, eye_w;
    logic [AW-1:0] win_addr;
    logic [2:0]    stage;
    logic [CW-1:0] det_count;
    logic [1:0]    state_dbg;

    logic          s_valid, s_busy, s_done;
    logic [DW-1:0] s_x, s_y, s_fw, s_fh, s_ew;
    logic [AW-1:0] s_addr;
    logic [2:0]    s_stage;
    logic [3:0]    sat_det;
    logic [1:0]    s_state;

    face_scan_sequencer #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .abort_i(abort),
        .unit_size_i(unit_size), .win_valid_o(win_valid), .win_ready_i(win_ready),
        .win_x_o(win_x), .win_y_o(win_y), .win_addr_o(win_addr),
        .filt_w_o(filt_w), .filt_h_o(filt_h), .eye_w_o(eye_w), .stage_o(stage),
        .hit_i(hit), .det_count_o(det_count), .busy_o(busy), .done_o(done),
        .state_o(state_dbg)
    );

    face_scan_sequencer #(.DW(DW), .AW(AW), .CW(4)) dut_sat (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .abort_i(abort),
        .unit_size_i(unit_size), .win_valid_o(s_valid), .win_ready_i(win_ready),
        .win_x_o(s_x), .win_y_o(s_y), .win_addr_o(s_addr),
        .filt_w_o(s_fw), .filt_h_o(s_fh), .eye_w_o(s_ew), .stage_o(s_stage),
        .hit_i(hit), .det_count_o(sat_det), .busy_o(s_busy), .done_o(s_done),
        .state_o(s_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    logic [DESC_W-1:0] exp_q[$];

    int    n_acc, hits, first_valid_cyc, done_cyc, last_acc_cyc;
    desc_t first_d, last_d;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: enumerate every window of every valid stage, row-major.
    task automatic build_model(input int u);
        int    w[1:6];
        int    tu, h, e;
        desc_t d;
        exp_q.delete();
        tu   = 3 * u;
        w[1] = (2 * u) / 3;
        w[2] = w[1] * 3 / 2;
        w[3] = w[2] * 3 / 2;
        w[4] = w[3] * 4 / 3;
        w[5] = w[4] * 5 / 4;
        w[6] = w[5] * 6 / 5 - 1;
        for (int s = 1; s <= 6; s++) begin
            h = w[s] / 6;
            e = w[s] / 5;
            if (h >= 1 && e >= 1 && tu >= w[s] + 1 && tu >= 4 * h + 1) begin
                for (int y = 0; y <= tu - 4 * h - 1; y++) begin
                    for (int x = 0; x <= tu - w[s] - 1; x++) begin
                        d.stage = 3'(s);
                        d.x     = DW'(x);
                        d.y     = DW'(y);
                        d.addr  = AW'(y * tu + x);
                        d.w     = DW'(w[s]);
                        d.h     = DW'(h);
                        d.e     = DW'(e);
                        exp_q.push_back(d);
                    end
                end
            end
        end
    endtask

    function automatic desc_t cur_desc();
        desc_t d;
        d.stage = stage;
        d.x     = win_x;
        d.y     = win_y;
        d.addr  = win_addr;
        d.w     = filt_w;
        d.h     = filt_h;
        d.e     = eye_w;
        return d;
    endfunction

    // Driver + scoreboard for one scan. Negative abort_at/rst_at/restart_at disable that event.
    task automatic scan(input int u, input int rdy_pct, input int hit_mod, input int hit_first,
                        input int abort_at, input int rst_at, input int restart_at);
        int    cyc;
        bit    fin, stall, do_hit;
        desc_t d, prev;
        logic [DESC_W-1:0] e;
        build_model(u);
        n_acc = 0; hits = 0; first_valid_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
        fin = 0; stall = 0; cyc = 0; prev = '0;
        @(negedge clk);
        unit_size = DW'(u);
        start = 1'b1;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; hit = 1'b0; abort = 1'b0;
            win_ready = ($urandom_range(99) < rdy_pct);
            if (cyc == 1) chk("det_cleared_on_start", det_count, 0);
            if (done) begin
                done_cyc = cyc;
                chk("done_valid_low", win_valid, 0);
                chk("done_det_count", det_count, hits);
                chk("done_sat_count", sat_det, (hits > 15) ? 15 : hits);
                fin = 1;
            end else if (win_valid) begin
                d = cur_desc();
                if (first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    first_d = d;
                end
                if (stall) chk("stall_hold", d, prev);
                if (n_acc == rst_at) begin
                    win_ready = 1'b0;
                    reset_n = 1'b0;
                    #1;
                    chk("rst_valid", win_valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_stage", stage, 0);
                    chk("rst_addr", win_addr, 0);
                    chk("rst_det", det_count, 0);
                    @(negedge clk);
                    reset_n = 1'b1;
                    fin = 1;
                end else if (n_acc == abort_at) begin
                    win_ready = 1'b0;
                    abort = 1'b1;
                    hit = 1'b1;
                    hits++;
                    @(negedge clk);
                    abort = 1'b0; hit = 1'b0;
                    chk("abort_valid", win_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_no_done", done, 0);
                    chk("abort_stage", stage, 0);
                    chk("abort_det", det_count, hits);
                    fin = 1;
                end else begin
                    if (n_acc == restart_at) start = 1'b1;
                    if (win_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("sb_extra_window", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sb_window", d, e);
                        end
                        do_hit = (n_acc < hit_first);
                        if (hit_mod > 0) begin
                            if (n_acc % hit_mod == 0) do_hit = 1;
                        end
                        if (do_hit) begin
                            hit = 1'b1;
                            hits++;
                        end
                        last_d = d;
                        last_acc_cyc = cyc;
                        n_acc++;
                    end
                    stall = !win_ready;
                    prev = d;
                end
            end
        end
        if (!fin) chk("scan_timeout", 0, 1);
        start = 1'b0; hit = 1'b0; abort = 1'b0; win_ready = 1'b0;
        if (abort_at < 0 && rst_at < 0) begin
            chk("sb_leftover", exp_q.size(), 0);
            if (n_acc > 0) begin
                chk("first_valid_latency", first_valid_cyc, 2);
                chk("done_after_last_accept", done_cyc, last_acc_cyc + 1);
            end else begin
                chk("empty_never_valid", first_valid_cyc < 0, 1);
                chk("empty_done_latency", done_cyc, 2);
            end
            @(negedge clk);
            chk("done_single_cycle", done, 0);
            chk("idle_after_done", busy, 0);
            chk("det_held_idle", det_count, hits);
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs = '{
            '{1, 100,   0, 0, 0,   0,  0},
            '{2, 100,   0, 0, 0,   0,  0},
            '{3, 100,  30, 5, 6,  38,  5},
            '{4,  60,  96, 5, 6,  89, 14},
            '{5, 100, 275, 3, 6, 153, 40},
            '{6, 100, 394, 2, 6, 162, 57},
            '{6,  50, 394, 2, 6, 162, 57}
        };

        // Reset
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", win_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stage", stage, 0);
        chk("reset_det", det_count, 0);
        chk("reset_addr", win_addr, 0);
        chk("reset_state", state_dbg, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            scan(vecs[i].u, vecs[i].rdy, 7, 0, -1, -1, -1);
            chk("tbl_windows", n_acc, vecs[i].windows);
            chk("tbl_det", det_count, vecs[i].det);
            if (vecs[i].windows > 0) begin
                chk("tbl_first_stage", first_d.stage, vecs[i].first_stage);
                chk("tbl_first_w", first_d.w, vecs[i].first_w);
                chk("tbl_first_addr", first_d.addr, 0);
                chk("tbl_last_addr", last_d.addr, vecs[i].last_addr);
            end
        end
        chk("u6_last_stage", last_d.stage, 6);
        chk("u6_last_y", last_d.y, 9);
        chk("u6_last_w", last_d.w, 17);

        for (int r = 0; r < 4; r++) begin
            scan($urandom_range(2, 10), $urandom_range(30, 100), $urandom_range(2, 9), 0, -1, -1, -1);
        end

        scan(6, 100, 0, 5, 100, -1, -1);
        chk("abort_det_six", det_count, 6);

        scan(6, 100, 0, 0, -1, 50, -1);
        scan(6, 100, 0, 0, -1, -1, -1);
        chk("post_reset_windows", n_acc, 394);

        scan(6, 100, 0, 20, -1, -1, 30);
        chk("restart_windows", n_acc, 394);
        chk("restart_det", det_count, 20);
        chk("sat_det_15", sat_det, 15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/face_scan_sequencer.md
Name: face_scan_sequencer

Overview:
- Sequences the multi-scale sliding-window scan for one face-detection core tile of 3U x 3U pixels, where U = unit_size.
- Generates one window descriptor per step for the detection datapath: origin, linear integral-image address and filter geometry.
- Walks the six filter stages in order and counts detections reported back by the datapath.
- Sits between the tile loader (which supplies start/unit_size) and the Haar-feature evaluator (window consumer).

Parameters:
DW, 16, width of unit_size, coordinates and filter geometry
AW, 32, width of linear window address
CW, 16, width of detection counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a scan, accepted only in IDLE
abort  in  1  synchronous; ends the scan, returns to IDLE, no done pulse
unit_size  in  DW  U; sampled on accepted start
win_valid  out  1  window descriptor valid
win_ready  in  1  evaluator accepts descriptor
win_x  out  DW  window left column
win_y  out  DW  window top row
win_addr  out  AW  win_y*3U + win_x
filt_w  out  DW  filter width for current stage
filt_h  out  DW  filter height = filt_w/6
eye_w  out  DW  eye segment width = filt_w/5
stage  out  3  current stage 1..6 (0 when idle)
hit  in  1  datapath detection pulse
det_count  out  CW  detections since last start, saturating
busy  out  1  high in CALC and SCAN
done  out  1  one-cycle pulse at normal scan completion

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including det_count.
- States: IDLE -> CALC -> SCAN -> DONE -> IDLE.
- IDLE: start=1 latches U, clears det_count, goes to CALC. start while busy is ignored.
- CALC (1 cycle): builds the stage table with integer floor division, all unsigned:
  - w1 = 2U/3; w2 = w1*3/2; w3 = w2*3/2; w4 = w3*4/3; w5 = w4*5/4; w6 = w5*6/5 - 1.
  - Per stage: h = w/6, e = w/5, XMAX = 3U - w - 1, YMAX = 3U - 4h - 1.
  - A stage is valid only if h >= 1, e >= 1, 3U >= w+1 and 3U >= 4h+1. Invalid stages are skipped.
  - Goes to SCAN at the first valid stage with x = y = 0. If no stage is valid, goes to DONE.
- Latency: first win_valid is high exactly 2 cycles after the start edge.
- SCAN:
  - win_valid = 1; all descriptor fields held stable until win_valid & win_ready.
  - On acceptance: if x < XMAX, x++ and addr++.
  - Else if y < YMAX: x = 0, y++, addr = row_base + 3U. row_base is an incremental register; no multiplier.
  - Else: advance to the next valid stage with x = y = 0, addr = 0.
  - After the last window of the last valid stage is accepted, go to DONE. win_valid drops in that same next cycle.
  - The next descriptor is presented in the cycle after acceptance, so sustained throughput is 1 window/cycle.
- DONE: done = 1 for one cycle, busy = 0, stage = 0, then IDLE. det_count holds its value until the next start.
- hit: counted in any cycle where busy = 1; saturates at 2^CW - 1.
- abort: highest priority after reset. Takes effect at the next edge from CALC or SCAN: IDLE, win_valid = 0, no done, det_count held.
- Simultaneous hit and abort: the hit is counted.
- Reset mid-scan: immediate return to IDLE and all outputs 0.

Test Plan:
- U=6, win_ready=1:
  - stage 1 skipped (w=4, h=0); first descriptor stage=2, x=0, y=0, addr=0, filt_w=6, filt_h=1, eye_w=1.
  - Window counts per stage 168/126/60/30/10, total 394.
  - Last descriptor stage=6, x=0, y=9, addr=162, filt_w=17, filt_h=2, eye_w=3.
  - done one cycle after final acceptance.
- U=6 with win_ready toggling randomly (~50%): descriptors never change while win_valid & !win_ready; same 394-window sequence and final det_count as the no-backpressure run.
- U=1: all stages invalid -> done pulses 2 cycles after start, win_valid never asserted, det_count=0.
- U=6, hit pulsed on 5 accepted windows plus one hit in the cycle abort is asserted, at window 100 -> IDLE next cycle, no done, det_count=6; a following start clears det_count to 0.
- reset driven low for 1 cycle mid-SCAN (U=6, window 50) -> outputs 0 asynchronously; a subsequent start yields a full 394-window scan.
- start pulsed again during SCAN -> ignored, window sequence uninterrupted; CW=4 with 20 hits -> det_count saturates at 15.
